// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller and the execute-stage operand muxes.
package hazard_pkg;

  // Sequencing states of the hazard controller.
  typedef enum logic [1:0] {
    INIT     = 2'b00,
    RUN      = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  // Execute-stage operand source select.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // True when a later stage writes a non-x0 register that matches the E-stage source.
  function automatic logic fwd_hit(input logic       reg_write,
                                   input logic [4:0] rd,
                                   input logic [4:0] rs);
    return reg_write && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding select for one E-stage source register; M wins over W, x0 never forwards.
module forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_m,
  input  logic                  reg_write_w,
  output fwd_sel_t              fwd_sel
);

  logic hit_m;
  logic hit_w;

  assign hit_m = reg_write_m && (rd_m != '0) && (rd_m == rs_e);
  assign hit_w = reg_write_w && (rd_w != '0) && (rd_w == rs_e);

  // Priority select: the younger result in M shadows the older one in W.
  always_comb begin
    // NOTE: a default on every path of always_comb keeps synthesis from inferring a latch.
    fwd_sel = FWD_RF;
    if (hit_m)      fwd_sel = FWD_M;
    else if (hit_w) fwd_sel = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the 5-stage RV32I core: stage stalls and
// flushes, E-stage forwarding selects, post-reset scrub, memory-wait freeze, stall counter
// and sticky memory-timeout flag.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W        = 5,
  parameter int INIT_FLUSH_CYCLES = 3,
  parameter int MEM_TIMEOUT       = 255,
  parameter int CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  LoadE,
  input  logic                  PCSrcE,
  input  logic                  MemAccessM,
  input  logic                  MemReadyM,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  StallW,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic [CNT_W-1:0]      StallCount,
  output logic                  MemTimeout
);

  localparam int INIT_W = $clog2(INIT_FLUSH_CYCLES + 1);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(INIT_FLUSH_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

  state_t             state_q, state_d;
  logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;

  logic               mem_stall;
  logic               lw_stall;
  logic               stall_f, stall_d, stall_e, stall_m, stall_w;
  logic               flush_d, flush_e;
  fwd_sel_t           fwd_a, fwd_b;

  assign mem_stall = MemAccessM && !MemReadyM;
  assign lw_stall  = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D)) && !PCSrcE;

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_sel     (fwd_a)
  );

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd_sel     (fwd_b)
  );

  // Next-state, counters and stage control; a memory stall overrides load-use and branch.
  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_f       = 1'b0;
    stall_d       = 1'b0;
    stall_e       = 1'b0;
    stall_m       = 1'b0;
    stall_w       = 1'b0;
    flush_d       = 1'b0;
    flush_e       = 1'b0;

    case (state_q)
      INIT: begin
        // Scrub: hold fetch and push bubbles into D and E; hazard inputs are ignored.
        stall_f = 1'b1;
        flush_d = 1'b1;
        flush_e = 1'b1;
        if (init_cnt_q == '0) state_d = RUN;
        else                  init_cnt_d = init_cnt_q - 1'b1;
      end

      RUN, MEM_WAIT: begin
        if (mem_stall) begin
          // Freeze everything; W re-writes the same register so W forwarding stays valid.
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
          stall_w = 1'b1;
          if (state_q == RUN) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = '0;
          end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
          if ((state_q == MEM_WAIT) && (wait_cnt_d == WAIT_MAX)) mem_timeout_d = 1'b1;
        end else begin
          // Release cycle (or normal flow): the branch in E is evaluated afresh here.
          state_d = RUN;
          if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
          if (PCSrcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end
        end
      end

      default: state_d = INIT;
    endcase

    stall_cnt_d = stall_cnt_q;
    if ((state_q != INIT) && stall_f && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // State and counter registers with asynchronous scrub restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= INIT;
      init_cnt_q    <= INIT_LOAD;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign StallF     = stall_f;
  assign StallD     = stall_d;
  assign StallE     = stall_e;
  assign StallM     = stall_m;
  assign StallW     = stall_w;
  assign FlushD     = flush_d;
  assign FlushE     = flush_e;
  assign ForwardAE  = (state_q == INIT) ? FWD_RF : fwd_a;
  assign ForwardBE  = (state_q == INIT) ? FWD_RF : fwd_b;
  assign StallCount = stall_cnt_q;
  assign MemTimeout = mem_timeout_q;

endmodule
